instr_encoder: RTL and testbench

INSTR_ENCODER -- requirements
Module: instr_encoder

---
 rtl/instr_encoder_pkg.sv | 41 ++++
 rtl/instr_fields.sv | 127 ++++++++++++
 rtl/instr_encoder.sv | 110 +++++++++++
 tb/tb_instr_encoder.sv | 229 ++++++++++++++++++++++
 4 files changed

// File: rtl/instr_encoder_pkg.sv
// instr_encoder_pkg
//   Shared constants for the RV32I instruction encoder: base opcodes (kept
//   identical to the control unit decoders), request kind codes, the NOP
//   word and the encoder FSM state type.
package instr_encoder_pkg;

    // RV32I base opcodes
    localparam logic [6:0] OPC_LOAD   = 7'b0000011;
    localparam logic [6:0] OPC_STORE  = 7'b0100011;
    localparam logic [6:0] OPC_R      = 7'b0110011;
    localparam logic [6:0] OPC_I      = 7'b0010011;
    localparam logic [6:0] OPC_BRANCH = 7'b1100011;
    localparam logic [6:0] OPC_AUIPC  = 7'b0010111;
    localparam logic [6:0] OPC_LUI    = 7'b0110111;
    localparam logic [6:0] OPC_JALR   = 7'b1100111;
    localparam logic [6:0] OPC_JAL    = 7'b1101111;

    // addi x0,x0,0
    localparam logic [31:0] NOP_WORD = 32'h0000_0013;

    // Request kinds carried on in_kind; codes 11..15 are invalid.
    typedef enum logic [3:0] {
        K_R      = 4'd0,
        K_I      = 4'd1,
        K_LOAD   = 4'd2,
        K_STORE  = 4'd3,
        K_BRANCH = 4'd4,
        K_LUI    = 4'd5,
        K_AUIPC  = 4'd6,
        K_JAL    = 4'd7,
        K_JALR   = 4'd8,
        K_LI     = 4'd9,
        K_CALL   = 4'd10
    } kind_e;

    typedef enum logic {
        ST_IDLE = 1'b0,
        ST_PEND = 1'b1
    } state_e;

endpackage

// File: rtl/instr_fields.sv
// instr_fields
//   Purely combinational field/immediate packer. Turns one request into
//   its first word, an optional second word (LI / CALL expansion) and
//   flags for "two words" and "invalid kind".
//   Ports:
//     kind, rd, rs1, rs2, funct3, alt, imm  - request fields
//     word0, word1                          - encoded words
//     two_words                             - word1 is meaningful
//     invalid                               - kind not recognised (word0 = NOP)
module instr_fields
    import instr_encoder_pkg::*;
#(
    parameter int DATA_WIDTH = 32,
    parameter int OP_WIDTH   = 7
) (
    input  logic [3:0]            kind,
    input  logic [4:0]            rd,
    input  logic [4:0]            rs1,
    input  logic [4:0]            rs2,
    input  logic [2:0]            funct3,
    input  logic                  alt,
    input  logic [DATA_WIDTH-1:0] imm,
    output logic [DATA_WIDTH-1:0] word0,
    output logic [DATA_WIDTH-1:0] word1,
    output logic                  two_words,
    output logic                  invalid
);

    logic [31:0]         imm32;
    logic [31:0]         hi_sum;
    logic                imm_small;
    logic [24:0]         body0;
    logic [24:0]         body1;
    logic [OP_WIDTH-1:0] opc0;
    logic [OP_WIDTH-1:0] opc1;
    logic [6:0]          funct7;

    assign imm32  = 32'(imm);
    // Adding 0x800 pre-compensates the sign extension of the low 12 bits
    // consumed by the following addi/jalr.
    assign hi_sum = imm32 + 32'h0000_0800;
    // Fits a 12-bit signed immediate when bits [31:11] are all equal.
    assign imm_small = (imm32[31:11] == '0) || (imm32[31:11] == '1);
    assign funct7    = {1'b0, alt, 5'b00000};

    always_comb begin
        body0     = '0;
        body1     = '0;
        opc0      = OP_WIDTH'(OPC_I);
        opc1      = OP_WIDTH'(OPC_I);
        two_words = 1'b0;
        invalid   = 1'b0;
        case (kind)
            K_R: begin
                body0 = {funct7, rs2, rs1, funct3, rd};
                opc0  = OP_WIDTH'(OPC_R);
            end
            K_I: begin
                if (funct3 == 3'b001 || funct3 == 3'b101)
                    body0 = {funct7, imm32[4:0], rs1, funct3, rd};
                else
                    body0 = {imm32[11:0], rs1, funct3, rd};
                opc0 = OP_WIDTH'(OPC_I);
            end
            K_LOAD: begin
                body0 = {imm32[11:0], rs1, funct3, rd};
                opc0  = OP_WIDTH'(OPC_LOAD);
            end
            K_STORE: begin
                body0 = {imm32[11:5], rs2, rs1, funct3, imm32[4:0]};
                opc0  = OP_WIDTH'(OPC_STORE);
            end
            K_BRANCH: begin
                body0 = {imm32[12], imm32[10:5], rs2, rs1, funct3,
                         imm32[4:1], imm32[11]};
                opc0  = OP_WIDTH'(OPC_BRANCH);
            end
            K_LUI: begin
                body0 = {imm32[31:12], rd};
                opc0  = OP_WIDTH'(OPC_LUI);
            end
            K_AUIPC: begin
                body0 = {imm32[31:12], rd};
                opc0  = OP_WIDTH'(OPC_AUIPC);
            end
            K_JAL: begin
                body0 = {imm32[20], imm32[10:1], imm32[11], imm32[19:12], rd};
                opc0  = OP_WIDTH'(OPC_JAL);
            end
            K_JALR: begin
                body0 = {imm32[11:0], rs1, 3'b000, rd};
                opc0  = OP_WIDTH'(OPC_JALR);
            end
            K_LI: begin
                if (imm_small) begin
                    body0 = {imm32[11:0], 5'd0, 3'b000, rd};
                    opc0  = OP_WIDTH'(OPC_I);
                end else begin
                    body0 = {hi_sum[31:12], rd};
                    opc0  = OP_WIDTH'(OPC_LUI);
                    // A zero low part needs no follow-up addi.
                    if (imm32[11:0] != '0) begin
                        body1     = {imm32[11:0], rd, 3'b000, rd};
                        opc1      = OP_WIDTH'(OPC_I);
                        two_words = 1'b1;
                    end
                end
            end
            K_CALL: begin
                body0     = {hi_sum[31:12], 5'd1};
                opc0      = OP_WIDTH'(OPC_AUIPC);
                body1     = {imm32[11:0], 5'd1, 3'b000, 5'd1};
                opc1      = OP_WIDTH'(OPC_JALR);
                two_words = 1'b1;
            end
            default: begin
                body0   = NOP_WORD[31:7];
                opc0    = OP_WIDTH'(NOP_WORD[6:0]);
                invalid = 1'b1;
            end
        endcase
    end

    assign word0 = DATA_WIDTH'({body0, 7'(opc0)});
    assign word1 = DATA_WIDTH'({body1, 7'(opc1)});

endmodule

// File: rtl/instr_encoder.sv
// instr_encoder
//   Valid/ready RV32I instruction encoder. Each accepted request yields one
//   word, or two words for LI (large immediate) and CALL. Output words are
//   registered; the second word follows the first with no bubble.
//   Ports:
//     clk, rst                      - clock, async active-high reset
//     in_valid / in_ready           - request handshake
//     in_kind, in_rd, in_rs1, in_rs2,
//     in_funct3, in_alt, in_imm     - request fields
//     out_valid / out_ready         - word handshake
//     out_instr                     - encoded word
//     out_last                      - final word of the request
//     err                           - one-cycle pulse when an invalid kind is accepted
module instr_encoder
    import instr_encoder_pkg::*;
#(
    parameter int DATA_WIDTH = 32,
    parameter int OP_WIDTH   = 7
) (
    input  logic                  clk,
    input  logic                  rst,
    input  logic                  in_valid,
    output logic                  in_ready,
    input  logic [3:0]            in_kind,
    input  logic [4:0]            in_rd,
    input  logic [4:0]            in_rs1,
    input  logic [4:0]            in_rs2,
    input  logic [2:0]            in_funct3,
    input  logic                  in_alt,
    input  logic [DATA_WIDTH-1:0] in_imm,
    output logic                  out_valid,
    input  logic                  out_ready,
    output logic [DATA_WIDTH-1:0] out_instr,
    output logic                  out_last,
    output logic                  err
);

    state_e                state;
    logic [DATA_WIDTH-1:0] word1_q;
    logic [DATA_WIDTH-1:0] f_word0;
    logic [DATA_WIDTH-1:0] f_word1;
    logic                  f_two;
    logic                  f_invalid;
    logic                  accept;
    logic                  out_fire;

    instr_fields #(
        .DATA_WIDTH (DATA_WIDTH),
        .OP_WIDTH   (OP_WIDTH)
    ) u_fields (
        .kind      (in_kind),
        .rd        (in_rd),
        .rs1       (in_rs1),
        .rs2       (in_rs2),
        .funct3    (in_funct3),
        .alt       (in_alt),
        .imm       (in_imm),
        .word0     (f_word0),
        .word1     (f_word1),
        .two_words (f_two),
        .invalid   (f_invalid)
    );

    assign in_ready = (state == ST_IDLE) && (!out_valid || out_ready);
    assign accept   = in_valid && in_ready;
    assign out_fire = out_valid && out_ready;

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state     <= ST_IDLE;
            out_valid <= 1'b0;
            out_instr <= DATA_WIDTH'(NOP_WORD);
            out_last  <= 1'b0;
            err       <= 1'b0;
            word1_q   <= DATA_WIDTH'(NOP_WORD);
        end else begin
            err <= accept && f_invalid;
            unique case (state)
                ST_IDLE: begin
                    if (accept) begin
                        out_valid <= 1'b1;
                        out_instr <= f_word0;
                        out_last  <= !f_two;
                        if (f_two) begin
                            word1_q <= f_word1;
                            state   <= ST_PEND;
                        end
                    end else if (out_fire) begin
                        out_valid <= 1'b0;
                    end
                end
                ST_PEND: begin
                    // out_last distinguishes the word0 handshake (swap in
                    // word1) from the word1 handshake (request done).
                    if (out_fire) begin
                        if (!out_last) begin
                            out_instr <= word1_q;
                            out_last  <= 1'b1;
                        end else begin
                            out_valid <= 1'b0;
                            state     <= ST_IDLE;
                        end
                    end
                end
                default: state <= ST_IDLE;
            endcase
        end
    end

endmodule

// File: tb/tb_instr_encoder.sv
// tb_instr_encoder
//   Directed-vector bench for instr_encoder with hand-computed words.
module tb_instr_encoder;
    import instr_encoder_pkg::*;

    logic        clk = 1'b0;
    logic        rst;
    logic        in_valid;
    logic        in_ready;
    logic [3:0]  in_kind;
    logic [4:0]  in_rd;
    logic [4:0]  in_rs1;
    logic [4:0]  in_rs2;
    logic [2:0]  in_funct3;
    logic        in_alt;
    logic [31:0] in_imm;
    logic        out_valid;
    logic        out_ready;
    logic [31:0] out_instr;
    logic        out_last;
    logic        err;

    int checks = 0;
    int errors = 0;

    instr_encoder #(
        .DATA_WIDTH (32),
        .OP_WIDTH   (7)
    ) dut (
        .clk       (clk),
        .rst       (rst),
        .in_valid  (in_valid),
        .in_ready  (in_ready),
        .in_kind   (in_kind),
        .in_rd     (in_rd),
        .in_rs1    (in_rs1),
        .in_rs2    (in_rs2),
        .in_funct3 (in_funct3),
        .in_alt    (in_alt),
        .in_imm    (in_imm),
        .out_valid (out_valid),
        .out_ready (out_ready),
        .out_instr (out_instr),
        .out_last  (out_last),
        .err       (err)
    );

    always #5 clk = ~clk;

    task automatic check(input string tag, input logic [31:0] got,
                         input logic [31:0] exp);
        checks++;
        if (got !== exp) begin
            errors++;
            $display("FAIL %s got=%h exp=%h", tag, got, exp);
        end
    endtask

    task automatic set_req(input logic [3:0] k, input logic [4:0] rd,
                           input logic [4:0] rs1, input logic [4:0] rs2,
                           input logic [2:0] f3, input logic alt,
                           input logic [31:0] imm);
        in_kind   = k;
        in_rd     = rd;
        in_rs1    = rs1;
        in_rs2    = rs2;
        in_funct3 = f3;
        in_alt    = alt;
        in_imm    = imm;
    endtask

    // Presents a request at a falling edge, waits (bounded) for in_ready,
    // and returns #1 after the accepting rising edge with in_valid low.
    task automatic send(input string tag, input logic [3:0] k,
                        input logic [4:0] rd, input logic [4:0] rs1,
                        input logic [4:0] rs2, input logic [2:0] f3,
                        input logic alt, input logic [31:0] imm);
        int n;
        @(negedge clk);
        set_req(k, rd, rs1, rs2, f3, alt, imm);
        in_valid = 1'b1;
        n = 0;
        while (!in_ready && n < 20) begin
            @(negedge clk);
            n++;
        end
        check({tag, "_accept_wait"}, 32'(in_ready), 32'd1);
        @(posedge clk);
        #1;
        in_valid = 1'b0;
    endtask

    task automatic step;
        @(posedge clk);
        #1;
    endtask

    initial begin
        rst       = 1'b1;
        in_valid  = 1'b0;
        out_ready = 1'b1;
        set_req(4'd0, 5'd0, 5'd0, 5'd0, 3'd0, 1'b0, 32'd0);

        // Reset state
        repeat (2) @(posedge clk);
        #1;
        check("rst_valid", 32'(out_valid), 32'd0);
        check("rst_instr", out_instr, 32'h0000_0013);
        check("rst_last",  32'(out_last),  32'd0);
        check("rst_err",   32'(err),       32'd0);
        check("rst_ready", 32'(in_ready),  32'd1);
        @(negedge clk);
        rst = 1'b0;

        // add x3,x1,x2: one word, latency 1
        send("add", K_R, 5'd3, 5'd1, 5'd2, 3'b000, 1'b0, 32'd0);
        check("add_valid", 32'(out_valid), 32'd1);
        check("add_instr", out_instr, 32'h0020_81B3);
        check("add_last",  32'(out_last),  32'd1);
        check("add_err",   32'(err),       32'd0);
        step();
        check("add_drain", 32'(out_valid), 32'd0);

        // LI x5,0x12345678: lui + addi
        send("li_big", K_LI, 5'd5, 5'd0, 5'd0, 3'b000, 1'b0, 32'h1234_5678);
        check("li_big_w0",    out_instr, 32'h1234_52B7);
        check("li_big_last0", 32'(out_last), 32'd0);
        check("li_big_rdy0",  32'(in_ready), 32'd0);
        step();
        check("li_big_w1",    out_instr, 32'h6782_8293);
        check("li_big_last1", 32'(out_last), 32'd1);
        check("li_big_v1",    32'(out_valid), 32'd1);
        step();
        check("li_big_done",  32'(out_valid), 32'd0);
        check("li_big_rdy",   32'(in_ready),  32'd1);

        // LI x5,-1: single addi
        send("li_m1", K_LI, 5'd5, 5'd0, 5'd0, 3'b000, 1'b0, 32'hFFFF_FFFF);
        check("li_m1_w0",   out_instr, 32'hFFF0_0293);
        check("li_m1_last", 32'(out_last), 32'd1);
        step();

        // LI x6,0x1800: sign-carry into the upper part
        send("li_carry", K_LI, 5'd6, 5'd0, 5'd0, 3'b000, 1'b0, 32'h0000_1800);
        check("li_carry_w0",    out_instr, 32'h0000_2337);
        check("li_carry_last0", 32'(out_last), 32'd0);
        step();
        check("li_carry_w1",    out_instr, 32'h8003_0313);
        check("li_carry_last1", 32'(out_last), 32'd1);
        step();

        // CALL 0x1800: auipc x1,2 ; jalr x1,x1,-2048
        send("call", K_CALL, 5'd0, 5'd0, 5'd0, 3'b000, 1'b0, 32'h0000_1800);
        check("call_w0", out_instr, 32'h0000_2097);
        step();
        check("call_w1",   out_instr, 32'h8000_80E7);
        check("call_last", 32'(out_last), 32'd1);
        step();

        // sw x2,-4(x1), beq x1,x2,-8, jal x1,2048
        send("sw", K_STORE, 5'd0, 5'd1, 5'd2, 3'b010, 1'b0, 32'hFFFF_FFFC);
        check("sw_w0", out_instr, 32'hFE20_AE23);
        send("beq", K_BRANCH, 5'd0, 5'd1, 5'd2, 3'b000, 1'b0, 32'hFFFF_FFF8);
        check("beq_w0", out_instr, 32'hFE20_8CE3);
        send("jal", K_JAL, 5'd1, 5'd0, 5'd0, 3'b000, 1'b0, 32'h0000_0800);
        check("jal_w0", out_instr, 32'h0010_00EF);
        step();

        // Back-to-back: sub x4,x5,x6 then srai x7,x8,3 in consecutive cycles
        @(negedge clk);
        set_req(K_R, 5'd4, 5'd5, 5'd6, 3'b000, 1'b1, 32'd0);
        in_valid = 1'b1;
        check("b2b_rdy0", 32'(in_ready), 32'd1);
        step();
        check("b2b_sub", out_instr, 32'h4062_8233);
        set_req(K_I, 5'd7, 5'd8, 5'd0, 3'b101, 1'b1, 32'd3);
        check("b2b_rdy1", 32'(in_ready), 32'd1);
        step();
        in_valid = 1'b0;
        check("b2b_srai",  out_instr, 32'h4034_5393);
        check("b2b_last",  32'(out_last),  32'd1);
        check("b2b_valid", 32'(out_valid), 32'd1);
        step();

        // Stall in PEND for 3 cycles, then reset mid-PEND
        out_ready = 1'b0;
        send("stall", K_LI, 5'd5, 5'd0, 5'd0, 3'b000, 1'b0, 32'h1234_5678);
        check("stall_w0", out_instr, 32'h1234_52B7);
        set_req(K_R, 5'd9, 5'd9, 5'd9, 3'b111, 1'b1, 32'hDEAD_BEEF);
        in_valid = 1'b1;
        for (int i = 0; i < 3; i++) begin
            step();
            check("stall_instr", out_instr, 32'h1234_52B7);
            check("stall_last",  32'(out_last),  32'd0);
            check("stall_valid", 32'(out_valid), 32'd1);
            check("stall_rdy",   32'(in_ready),  32'd0);
        end
        in_valid = 1'b0;
        rst = 1'b1;
        #1;
        check("midrst_valid", 32'(out_valid), 32'd0);
        check("midrst_instr", out_instr, 32'h0000_0013);
        check("midrst_last",  32'(out_last),  32'd0);
        @(negedge clk);
        rst = 1'b0;
        out_ready = 1'b1;
        for (int i = 0; i < 3; i++) begin
            step();
            check("postrst_idle", 32'(out_valid), 32'd0);
        end
        send("postrst_add", K_R, 5'd3, 5'd1, 5'd2, 3'b000, 1'b0, 32'd0);
        check("postrst_add_w", out_instr, 32'h0020_81B3);
        check("postrst_add_l", 32'(out_last), 32'd1);
        step();

        // Invalid kind 4'hF: NOP and a single-cycle err pulse
        send("bad", 4'hF, 5'd1, 5'd2, 5'd3, 3'b000, 1'b0, 32'h0000_0123);
        check("bad_instr", out_instr, 32'h0000_0013);
        check("bad_last",  32'(out_last), 32'd1);
        check("bad_err",   32'(err),      32'd1);
        step();
        check("bad_err_off", 32'(err),      32'd0);
        check("bad_drain",   32'(out_valid), 32'd0);

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
